// File: rtl/ifetch_axi_rd_master_if.sv
// ---------------------------------------------------------------------------
// ifetch_axi_rd_master_if
// AXI4 read-address / read-data channel bundle between the instruction-fetch
// read master and the interconnect or instruction-memory slave.
//
// Signals:
//   m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid  master -> slave
//   m_arready                                                  slave -> master
//   m_rdata, m_rresp, m_rlast, m_rvalid                        slave -> master
//   m_rready                                                   master -> slave
// Modports: master (read master side), slave (memory / interconnect side).
// ---------------------------------------------------------------------------
interface ifetch_axi_rd_master_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [31:0]       m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;

  modport master (
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

  modport slave (
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );
endinterface

// File: rtl/ifetch_axi_rd_master.sv
// ---------------------------------------------------------------------------
// ifetch_axi_rd_master
// Single-outstanding AXI4 read master for the instruction-fetch stage. A
// one-cycle start pulse with a PC issues one single-beat 32-bit read; the
// instruction word comes back with a one-cycle done pulse.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   axi_start  in   one-cycle request pulse (ignored while axi_busy)
//   axi_addr   in   fetch PC, sampled with axi_start
//   axi_done   out  one-cycle completion pulse
//   axi_rdata  out  instruction word, held until the next done
//   axi_err    out  qualifies axi_done (misaligned, non-OKAY, timeout)
//   axi_busy   out  transaction in progress
//   m_axi      AXI4 AR/R channels (master modport)
//
// Optional build macro IFETCH_TIMEOUT_EN: adds a watchdog that completes the
// request with an error after TIMEOUT_CYCLES cycles in AR/R, then drains the
// outstanding read in a DRAIN state without a second done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no transaction; accepts axi_start
// AR    | m_arvalid high, waiting for m_arready
// R     | m_rready high, waiting for the rlast beat
// DRAIN | request already answered by timeout; absorbing the late read
// ---------------------------------------------------------------------------
module ifetch_axi_rd_master #(
  parameter int          ADDR_W         = 32,
  parameter int          ID_W           = 4,
  parameter int unsigned ARID_VAL       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 axi_start,
  input  logic [ADDR_W-1:0]    axi_addr,
  output logic                 axi_done,
  output logic [31:0]          axi_rdata,
  output logic                 axi_err,
  output logic                 axi_busy,
  ifetch_axi_rd_master_if.master m_axi
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_R     = 2'd2
`ifdef IFETCH_TIMEOUT_EN
    , S_DRAIN = 2'd3
`endif
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_araddr;
  logic [31:0]       r_rdata, w_rdata_nxt;
  logic              r_done, r_err;
  logic              w_done_nxt, w_err_nxt, w_rdata_ld, w_addr_ld;
  logic              w_arvalid, w_rready, w_ar_hs, w_r_last_hs;

  assign w_arvalid = (r_state == S_AR);
`ifdef IFETCH_TIMEOUT_EN
  assign w_rready  = (r_state == S_R) || (r_state == S_DRAIN);
`else
  assign w_rready  = (r_state == S_R);
`endif
  assign w_ar_hs     = w_arvalid && m_axi.m_arready;
  assign w_r_last_hs = w_rready && m_axi.m_rvalid && m_axi.m_rlast;

`ifdef IFETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_tmo;
  logic             w_tmo_exp;

  // Fires once, on the TIMEOUT_CYCLES-th cycle spent in AR/R.
  assign w_tmo_exp = ((r_state == S_AR) || (r_state == S_R)) && !r_tmo &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else if (w_addr_ld) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else if ((r_state == S_AR) || (r_state == S_R)) begin
      if (w_tmo_exp) r_tmo <= 1'b1;
      if (r_cnt != CNT_W'(TIMEOUT_CYCLES - 1)) r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  // Keeps the parameter list identical in both builds.
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_ld  = 1'b0;
    w_rdata_nxt = '0;
    w_addr_ld   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (axi_start) begin
          if (axi_addr[1:0] == 2'b00) begin
            w_addr_ld   = 1'b1;
            w_state_nxt = S_AR;
          end else begin
            // Misaligned: answer locally, never touch the bus.
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
            w_rdata_ld = 1'b1;
          end
        end
      end
      S_AR: begin
        if (w_ar_hs) w_state_nxt = S_R;
`ifdef IFETCH_TIMEOUT_EN
        // Expiry in AR answers the request now but keeps arvalid up, since
        // an AXI master may not withdraw a valid before its handshake.
        if (w_tmo_exp) begin
          w_done_nxt = 1'b1;
          w_err_nxt  = 1'b1;
          w_rdata_ld = 1'b1;
        end
        if (w_ar_hs && (r_tmo || w_tmo_exp)) w_state_nxt = S_DRAIN;
`endif
      end
      S_R: begin
        if (w_r_last_hs) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = (m_axi.m_rresp != 2'b00);
          w_rdata_ld  = 1'b1;
          w_rdata_nxt = (m_axi.m_rresp == 2'b00) ? m_axi.m_rdata : 32'h0;
          w_state_nxt = S_IDLE;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (w_tmo_exp) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_rdata_ld  = 1'b1;
          w_state_nxt = S_DRAIN;
        end
`endif
      end
`ifdef IFETCH_TIMEOUT_EN
      S_DRAIN: begin
        if (w_r_last_hs) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr <= '0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
      if (w_addr_ld)  r_araddr <= axi_addr;
      if (w_rdata_ld) r_rdata  <= w_rdata_nxt;
    end
  end

  assign axi_done  = r_done;
  assign axi_err   = r_err;
  assign axi_rdata = r_rdata;
  assign axi_busy  = (r_state != S_IDLE);

  assign m_axi.m_arid    = ID_W'(ARID_VAL);
  assign m_axi.m_araddr  = r_araddr;
  assign m_axi.m_arlen   = 8'd0;
  assign m_axi.m_arsize  = 3'b010;
  assign m_axi.m_arburst = 2'b01;
  assign m_axi.m_arvalid = w_arvalid;
  assign m_axi.m_rready  = w_rready;

endmodule

// File: doc/ifetch_axi_rd_master.md
Name: ifetch_axi_rd_master

Overview:
- Single-outstanding AXI4 read master that serves the instruction-fetch stage's user-side request interface.
- Accepts a one-cycle start pulse with a PC.
- Issues one single-beat 32-bit AXI read.
- Returns the instruction word with a one-cycle done pulse.
- Sits between the fetch stage and the AXI interconnect or instruction-memory slave.

Parameters:
- ADDR_W, 32, AXI/user address width.
- ID_W, 4, ARID width.
- ARID_VAL, 0, constant value driven on arid.
- TIMEOUT_CYCLES, 256, watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- axi_start  in  1  one-cycle request pulse from fetch
- axi_addr  in  ADDR_W  fetch PC, sampled with axi_start
- axi_done  out  1  one-cycle pulse, read complete
- axi_rdata  out  32  instruction word, valid while axi_done=1 and held until the next done
- axi_err  out  1  qualifies axi_done: misaligned address, non-OKAY response, or timeout
- axi_busy  out  1  transaction in progress; start is ignored while high
- m_arid  out  ID_W  = ARID_VAL
- m_araddr  out  ADDR_W  latched PC
- m_arlen  out  8  constant 0
- m_arsize  out  3  constant 3'b010
- m_arburst  out  2  constant 2'b01 (INCR)
- m_arvalid  out  1  AR valid
- m_arready  in  1  AR ready
- m_rdata  in  32  read data
- m_rresp  in  2  read response
- m_rlast  in  1  last beat
- m_rvalid  in  1  R valid
- m_rready  out  1  R ready

Behaviour:
- States: IDLE, AR, R, DRAIN. DRAIN is reachable only with the optional feature.
- Reset values: state=IDLE, m_arvalid=0, m_rready=0, m_araddr=0, axi_done=0, axi_err=0, axi_rdata=0, axi_busy=0.
- Reset mid-transaction forces IDLE immediately; the bench resets the slave together with this block.
- axi_busy = (state != IDLE). It is a combinational decode of state.
- IDLE:
  - axi_start=1 with axi_addr[1:0]==0: latch m_araddr<=axi_addr, go to AR.
  - axi_start=1 with a misaligned address: no bus activity; next cycle axi_done=1, axi_err=1, axi_rdata=0; stay in IDLE.
  - axi_start=0: no action.
- AR:
  - m_arvalid=1 and m_araddr held stable.
  - On m_arvalid&&m_arready: m_arvalid<=0, go to R.
  - m_arvalid never drops before the handshake.
- R:
  - m_rready=1.
  - On m_rvalid&&m_rready&&m_rlast: capture axi_rdata<=m_rdata (or 0 if m_rresp!=2'b00), axi_err<=(m_rresp!=0), axi_done<=1, go to IDLE.
  - A beat with m_rlast=0 is consumed and discarded; remain in R.
- axi_done is registered and lasts exactly one cycle.
  - It appears the cycle after the final R handshake, when axi_busy is already 0.
  - A new axi_start is therefore legal in the same cycle as axi_done.
- axi_err is valid only with axi_done and is cleared to 0 in every other cycle.
- axi_start while axi_busy=1 is ignored. No queueing, no error.
- Minimum latency with an always-ready slave:
  - start sampled at edge 0.
  - arvalid high in cycle 1.
  - rready high in cycle 2.
  - axi_done in cycle 3.
- Exactly one outstanding transaction at any time.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- Defined:
  - A counter, reset on entry to AR, increments each cycle in AR or R.
  - When it reaches TIMEOUT_CYCLES: pulse axi_done=1, axi_err=1, axi_rdata=0.
  - If expiry occurs in R: go to DRAIN.
  - If expiry occurs in AR: keep m_arvalid=1 until the handshake, then go to DRAIN.
  - DRAIN: m_rready=1, axi_busy=1, no second done; return to IDLE on the rlast handshake.
- Undefined: no counter and no DRAIN state; the block waits indefinitely.

Test Plan:
- Always-ready slave, start with addr=0x34, rdata=0x3C010000 -> araddr=0x34, arlen=0, arsize=2; axi_done in cycle 3; axi_rdata=0x3C010000; axi_err=0.
- arready delayed 5 cycles, rvalid delayed 3 cycles -> arvalid and araddr stable throughout; exactly one done pulse; axi_busy=1 from cycle 1 until the R handshake.
- Start with addr=0x36 -> no arvalid ever; done the next cycle with axi_err=1 and axi_rdata=0.
- Slave returns rresp=2'b10 -> axi_done=1, axi_err=1, axi_rdata=0; the next request with addr=0x38 completes normally.
- Second start pulse while busy, plus a back-to-back start in the done cycle -> the busy-cycle start is ignored; the done-cycle start issues a new AR one cycle later.
- Reset asserted while in R, and (with IFETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8) a slave that never responds:
  - Reset case: outputs return to reset values next cycle.
  - Timeout case: done with err after 8 cycles; a late rlast beat is absorbed with no extra done.
